// File: rtl/io_lane_pkg.sv
`default_nettype none
// ============================================================================
// Module      : io_lane_pkg
// Description : Shared definitions for the I/O lane arbiter: controller state
//               encoding, default invert mask and a width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package io_lane_pkg;

    // Controller states
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    // Default invert mask: every lane inverted
    localparam logic [7:0] MASK_RST_DEFAULT = 8'hFF;

    // Index width for n entries, never less than one bit
    function automatic int lane_clog2(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/io_lane_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin priority encoder. Returns the first
//               requester with req set, searching rr_ptr, rr_ptr+1, ...
//               modulo NREQ.
// Ports       : req    - request vector
//               rr_ptr - index with highest priority
//               pick   - selected index (valid when any=1)
//               any    - at least one request present
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   rr_ptr,
    output logic [IW-1:0]   pick,
    output logic            any
);

    logic [2*NREQ-1:0] w_dbl;
    logic [NREQ-1:0]   w_rot;
    logic [IW:0]       w_first;
    logic [IW:0]       w_sum;

    // Rotate so that bit 0 of w_rot is the requester at rr_ptr
    assign w_dbl = {req, req} >> rr_ptr;
    assign w_rot = w_dbl[NREQ-1:0];
    assign any   = |req;

    always_comb begin
        w_first = '0;
        // Descending scan: lowest rotated offset wins
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_first = (IW+1)'(k);
            end
        end
        // Un-rotate; the extra bit keeps the sum exact for non-power-of-2 NREQ
        w_sum = {1'b0, rr_ptr} + w_first;
        if (w_sum >= (IW+1)'(NREQ)) begin
            w_sum = w_sum - (IW+1)'(NREQ);
        end
        pick = w_sum[IW-1:0];
    end

endmodule
`default_nettype wire

// File: rtl/io_lane_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : io_lane_arbiter
// Description : Round-robin arbiter sharing one registered DW-bit output lane
//               bank between NREQ requesters. The granted requester's data
//               leaves XORed with its programmable invert mask. Grants are
//               limited to MAX_BURST consecutive beats while others wait.
// Ports       : clk, rst_n          - clock, async active-low reset
//               req, req_data       - per-requester request level and data
//               gnt                 - registered one-hot-or-zero grant
//               cfg_we/idx/mask     - invert-mask table write port
//               out_data/valid/owner- registered lane output and its source
//               busy                - a grant is active
// Revision    : 1.0 - initial release
// ============================================================================
module io_lane_arbiter
    import io_lane_pkg::*;
#(
    parameter int            NREQ      = 4,
    parameter int            DW        = 8,
    parameter int            MAX_BURST = 4,
    parameter logic [DW-1:0] MASK_RST  = DW'(MASK_RST_DEFAULT),
    localparam int           IW        = lane_clog2(NREQ),
    localparam int           BW        = lane_clog2(MAX_BURST)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    gnt,
    input  logic               cfg_we,
    input  logic [IW-1:0]      cfg_idx,
    input  logic [DW-1:0]      cfg_mask,
    output logic [DW-1:0]      out_data,
    output logic               out_valid,
    output logic [IW-1:0]      out_owner,
    output logic               busy
);

    logic [0:0]      state_q,     state_d;
    logic [NREQ-1:0] gnt_q,       gnt_d;
    logic [IW-1:0]   owner_q,     owner_d;
    logic [IW-1:0]   rr_ptr_q,    rr_ptr_d;
    logic [BW-1:0]   burst_q,     burst_d;
    logic [DW-1:0]   out_data_q,  out_data_d;
    logic            out_valid_q, out_valid_d;
    logic [IW-1:0]   out_owner_q, out_owner_d;
    logic [DW-1:0]   mask_q [NREQ];
    logic [DW-1:0]   mask_d [NREQ];

    logic [DW-1:0]   w_data [NREQ];
    logic [IW-1:0]   w_owner_next;
    logic [IW-1:0]   w_pick_ptr;
    logic [IW-1:0]   w_pick;
    logic            w_any;
    logic            w_beat;
    logic            w_others;
    logic            w_last;

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign w_data[i] = req_data[i*DW +: DW];
    end

    assign w_owner_next = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + IW'(1);

    // While granted, the only pick ever used is the hand-off one, which
    // searches from the slot after the current owner; that is exactly where
    // rr_ptr lands on release, so the next grant is ready on the same edge.
    assign w_pick_ptr = (state_q == ST_GRANT) ? w_owner_next : rr_ptr_q;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_pick (
        .req    (req),
        .rr_ptr (w_pick_ptr),
        .pick   (w_pick),
        .any    (w_any)
    );

    assign w_beat   = (state_q == ST_GRANT) && req[owner_q];
    assign w_others = |(req & ~gnt_q);
    assign w_last   = (burst_q == BW'(MAX_BURST - 1));

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        burst_d     = burst_q;
        out_data_d  = out_data_q;
        out_owner_d = out_owner_q;
        out_valid_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (w_any) begin
                    state_d        = ST_GRANT;
                    gnt_d          = '0;
                    gnt_d[w_pick]  = 1'b1;
                    owner_d        = w_pick;
                    burst_d        = '0;
                end
            end
            ST_GRANT: begin
                if (w_beat) begin
                    out_valid_d = 1'b1;
                    out_data_d  = w_data[owner_q] ^ mask_q[owner_q];
                    out_owner_d = owner_q;
                    burst_d     = burst_q + BW'(1);
                end
                // Release on owner drop, or on burst end when someone waits
                if (!req[owner_q] || (w_last && w_others)) begin
                    rr_ptr_d = w_owner_next;
                    burst_d  = '0;
                    gnt_d    = '0;
                    if (w_any) begin
                        gnt_d[w_pick] = 1'b1;
                        owner_d       = w_pick;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (w_last) begin
                    // Burst limit reached with nobody waiting: keep going
                    burst_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // Write lands at the edge, so a beat on that same edge still sees the old mask
    always_comb begin
        mask_d = mask_q;
        for (int i = 0; i < NREQ; i++) begin
            if (cfg_we && (cfg_idx == IW'(i))) begin
                mask_d[i] = cfg_mask;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            gnt_q       <= '0;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            burst_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_owner_q <= '0;
            for (int i = 0; i < NREQ; i++) begin
                mask_q[i] <= MASK_RST;
            end
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_q     <= burst_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_owner_q <= out_owner_d;
            mask_q      <= mask_d;
        end
    end

    assign gnt       = gnt_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_owner = out_owner_q;
    assign busy      = (state_q == ST_GRANT);

endmodule
`default_nettype wire
